// File: rtl/nfu_3_if.sv
// Lane-vector handshake and coefficient config bus for the NFU-3 activation stage.
// NFU3_RELU_MODE_EN adds the per-vector i_relu select.
`timescale 1ns/1ps

interface nfu_3_if #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned Tn        = 16
);
    logic                      i_valid;
    logic                      o_ready;
    logic [BIT_WIDTH*Tn-1:0]   i_data;
    logic                      o_valid;
    logic                      i_ready;
    logic [BIT_WIDTH*Tn-1:0]   o_data;
    logic                      i_cfg_we;
    logic [3:0]                i_cfg_addr;
    logic [BIT_WIDTH-1:0]      i_cfg_a;
    logic [BIT_WIDTH-1:0]      i_cfg_b;
`ifdef NFU3_RELU_MODE_EN
    logic                      i_relu;

    modport master (
        output i_valid, i_data, i_ready, i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b, i_relu,
        input  o_ready, o_valid, o_data
    );
    modport slave (
        input  i_valid, i_data, i_ready, i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b, i_relu,
        output o_ready, o_valid, o_data
    );
`else
    modport master (
        output i_valid, i_data, i_ready, i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b,
        input  o_ready, o_valid, o_data
    );
    modport slave (
        input  i_valid, i_data, i_ready, i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b,
        output o_ready, o_valid, o_data
    );
`endif
endinterface

// File: rtl/nfu_3.sv
// NFU-3: 16-segment piecewise-linear activation on Tn sign-magnitude lanes, 3-stage valid/ready pipe.
// Optional ReLU bypass selected per vector when NFU3_RELU_MODE_EN is defined.
`timescale 1ns/1ps

module nfu_3 #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned Q         = 10,
    parameter int unsigned Tn        = 16
) (
    input  logic   clk,
    input  logic   rst,
    nfu_3_if.slave bus
);
    localparam int unsigned MW   = BIT_WIDTH - 1;   // magnitude bits
    localparam int unsigned IW   = MW - Q;          // integer magnitude bits
    localparam int unsigned CW   = IW + 1;          // ceil of magnitude can carry
    localparam int unsigned PW   = 2 * MW - Q;      // product magnitude after >> Q
    localparam int unsigned SW   = PW + 1;          // add result with carry
    localparam int unsigned NSEG = 16;
    localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1 << Q);

    // Segment = clamp(floor(x), -8, 7) + 8 on the signed value; -0 maps like +0.
    function automatic logic [3:0] seg_of(input logic [BIT_WIDTH-1:0] x);
        logic [MW-1:0] mag;
        logic [IW-1:0] ip;
        logic [CW-1:0] ceil_m;
        mag = x[MW-1:0];
        ip  = mag[MW-1:Q];
        if (!x[MW] || (mag == '0)) begin
            seg_of = (ip >= IW'(7)) ? 4'd15 : (4'(ip) + 4'd8);
        end else begin
            ceil_m = {1'b0, ip} + CW'(mag[Q-1:0] != '0);
            seg_of = (ceil_m >= CW'(8)) ? 4'd0 : (4'd8 - 4'(ceil_m));
        end
    endfunction

    function automatic logic [PW-1:0] mul_q(input logic [MW-1:0] x, input logic [MW-1:0] a);
        logic [2*MW-1:0] full;
        full  = (2*MW)'(x) * (2*MW)'(a);
        mul_q = PW'(full >> Q);
    endfunction

    // Sign-magnitude add with magnitude saturation; zero always leaves as +0.
    function automatic logic [BIT_WIDTH-1:0] sm_add(input logic sp, input logic [PW-1:0] p,
                                                    input logic [BIT_WIDTH-1:0] b);
        logic [SW-1:0] pm;
        logic [SW-1:0] bm;
        logic [SW-1:0] mag;
        logic          sg;
        pm = SW'(p);
        bm = SW'(b[MW-1:0]);
        if (sp == b[MW]) begin
            mag = pm + bm;
            sg  = sp;
        end else if (pm >= bm) begin
            mag = pm - bm;
            sg  = sp;
        end else begin
            mag = bm - pm;
            sg  = b[MW];
        end
        if (mag == '0)                      sm_add = '0;
        else if (mag > SW'({MW{1'b1}}))     sm_add = {sg, {MW{1'b1}}};
        else                                sm_add = {sg, mag[MW-1:0]};
    endfunction

    logic [BIT_WIDTH-1:0]    r_a [NSEG];
    logic [BIT_WIDTH-1:0]    r_b [NSEG];
    logic                    r_v1, r_v2, r_v3;
    logic [BIT_WIDTH-1:0]    r_x1 [Tn];
    logic [BIT_WIDTH-1:0]    r_a1 [Tn];
    logic [BIT_WIDTH-1:0]    r_b1 [Tn];
    logic [PW-1:0]           r_p2 [Tn];
    logic                    r_s2 [Tn];
    logic [BIT_WIDTH-1:0]    r_b2 [Tn];
    logic [BIT_WIDTH*Tn-1:0] r_y3;
`ifdef NFU3_RELU_MODE_EN
    logic                    r_relu1;
`endif

    logic                    w_adv;
    logic [3:0]              w_seg [Tn];

    assign w_adv       = ~(r_v3 & ~bus.i_ready);
    assign bus.o_ready = w_adv;
    assign bus.o_valid = r_v3;
    assign bus.o_data  = r_y3;

    always_comb begin
        for (int k = 0; k < Tn; k++) begin
            w_seg[k] = seg_of(bus.i_data[k*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    // Coefficient table: written regardless of stalls; stage-1 reads see pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                r_a[i] <= ONE;
                r_b[i] <= '0;
            end
        end else if (bus.i_cfg_we) begin
            r_a[bus.i_cfg_addr] <= bus.i_cfg_a;
            r_b[bus.i_cfg_addr] <= bus.i_cfg_b;
        end
    end

    // Three lock-step stages; data of each stage loads only behind a valid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_y3 <= '0;
`ifdef NFU3_RELU_MODE_EN
            r_relu1 <= 1'b0;
`endif
            for (int k = 0; k < Tn; k++) begin
                r_x1[k] <= '0;
                r_a1[k] <= '0;
                r_b1[k] <= '0;
                r_p2[k] <= '0;
                r_s2[k] <= 1'b0;
                r_b2[k] <= '0;
            end
        end else if (w_adv) begin
            r_v1 <= bus.i_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
`ifdef NFU3_RELU_MODE_EN
            if (bus.i_valid) r_relu1 <= bus.i_relu;
`endif
            for (int k = 0; k < Tn; k++) begin
                if (bus.i_valid) begin
                    r_x1[k] <= bus.i_data[k*BIT_WIDTH +: BIT_WIDTH];
                    r_a1[k] <= r_a[w_seg[k]];
                    r_b1[k] <= r_b[w_seg[k]];
                end
                if (r_v1) begin
`ifdef NFU3_RELU_MODE_EN
                    if (r_relu1) begin
                        r_p2[k] <= (!r_x1[k][MW] && (r_x1[k][MW-1:0] != '0)) ?
                                   PW'(r_x1[k][MW-1:0]) : '0;
                        r_s2[k] <= 1'b0;
                        r_b2[k] <= '0;
                    end else
`endif
                    begin
                        r_p2[k] <= mul_q(r_x1[k][MW-1:0], r_a1[k][MW-1:0]);
                        r_s2[k] <= r_x1[k][MW] ^ r_a1[k][MW];
                        r_b2[k] <= r_b1[k];
                    end
                end
                if (r_v2) begin
                    r_y3[k*BIT_WIDTH +: BIT_WIDTH] <= sm_add(r_s2[k], r_p2[k], r_b2[k]);
                end
            end
        end
    end
endmodule

// File: tb/tb_nfu_3.sv
// Scoreboard bench for nfu_3: driver pushes expected vectors, monitor pops on each output transfer.
`timescale 1ns/1ps

module tb_nfu_3;
    localparam int unsigned BW = 16;
    localparam int unsigned TN = 16;
    localparam int unsigned DW = BW * TN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfu_3_if #(.BIT_WIDTH(BW), .Tn(TN)) bus ();
    nfu_3 #(.BIT_WIDTH(BW), .Q(10), .Tn(TN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [BW-1:0] a_tab[16];
    logic [BW-1:0] b_tab[16];
    int ready_mode = 0;
    int stream_cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            a_tab[i] = 16'h0400;
            b_tab[i] = 16'h0000;
        end
    endtask

    // Reference: signed integer arithmetic in units of 2^-10, then re-encoded as sign-magnitude.
    function automatic logic [BW-1:0] model_lane(input logic [BW-1:0] x);
        int xm, xs, fl, seg, am, p, bs, y;
        logic [BW-1:0] a, b;
        xm  = int'(x[14:0]);
        xs  = x[15] ? -xm : xm;
        fl  = $rtoi($floor($itor(xs) / 1024.0));
        if (fl < -8) fl = -8;
        if (fl > 7)  fl = 7;
        seg = fl + 8;
        a   = a_tab[seg];
        b   = b_tab[seg];
        am  = int'(a[14:0]);
        p   = (xm * am) / 1024;
        if (x[15] ^ a[15]) p = -p;
        bs  = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        y   = p + bs;
        if (y > 32767)  y = 32767;
        if (y < -32767) y = -32767;
        if (y == 0)     return 16'h0000;
        if (y < 0)      return {1'b1, 15'(-y)};
        return {1'b0, 15'(y)};
    endfunction

    function automatic logic [DW-1:0] model_vec(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < TN; k++) r[k*BW +: BW] = model_lane(d[k*BW +: BW]);
        return r;
    endfunction

    function automatic logic [DW-1:0] fill2(input logic [BW-1:0] ev, input logic [BW-1:0] od);
        logic [DW-1:0] r;
        for (int k = 0; k < TN; k++) r[k*BW +: BW] = (k % 2 == 0) ? ev : od;
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_sm(input int maxmag);
        logic [14:0] m;
        m = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, maxmag));
        return {1'($urandom_range(0, 1)), m};
    endfunction

    function automatic logic next_ready();
        logic r;
        case (ready_mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 3) != 0);
            default: r = !(stream_cyc >= 4 && stream_cyc <= 6);
        endcase
        return r;
    endfunction

    // One clock: drive after the edge, decide acceptance mid-cycle, return after the next edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic we, input logic [3:0] ad,
                         input logic [BW-1:0] ca, input logic [BW-1:0] cb, input logic use_exp,
                         input logic [DW-1:0] ex, output logic acc, output logic ov);
        bus.i_valid    = v;
        bus.i_data     = d;
        bus.i_ready    = next_ready();
        bus.i_cfg_we   = we;
        bus.i_cfg_addr = ad;
        bus.i_cfg_a    = ca;
        bus.i_cfg_b    = cb;
        stream_cyc++;
        @(negedge clk);
        ov  = bus.o_valid;
        acc = v && bus.o_ready && !rst;
        if (acc) exp_q.push_back(use_exp ? ex : model_vec(d));
        if (we && !rst) begin
            a_tab[ad] = ca;
            b_tab[ad] = cb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(output logic ov);
        logic acc;
        cycle(1'b0, '0, 1'b0, 4'd0, '0, '0, 1'b0, '0, acc, ov);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic use_exp, input logic [DW-1:0] ex,
                        input logic we, input logic [3:0] ad, input logic [BW-1:0] ca,
                        input logic [BW-1:0] cb);
        logic acc, ov, w;
        int tries;
        acc = 1'b0;
        tries = 0;
        w = we;
        while (!acc && tries < 64) begin
            cycle(1'b1, d, w, ad, ca, cb, use_exp, ex, acc, ov);
            w = 1'b0;
            tries++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: vector not accepted after %0d cycles, required acceptance", tries);
        end
    endtask

    task automatic cfg_write(input logic [3:0] ad, input logic [BW-1:0] ca, input logic [BW-1:0] cb);
        logic acc, ov;
        cycle(1'b0, '0, 1'b1, ad, ca, cb, 1'b0, '0, acc, ov);
    endtask

    task automatic drain(input string name);
        logic ov;
        int n;
        n = 0;
        ready_mode = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(ov);
            n++;
        end
        idle(ov);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin : monitor
        logic [DW-1:0] e;
        logic [DW-1:0] pd;
        logic ps;
        ps = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ps = 1'b0;
            end else begin
                checks++;
                if (bus.o_ready !== !(bus.o_valid && !bus.i_ready)) begin
                    failures++;
                    $display("FAIL o_ready: got %b with o_valid=%b i_ready=%b", bus.o_ready, bus.o_valid, bus.i_ready);
                end
                if (ps) begin
                    checks++;
                    if (bus.o_valid !== 1'b1 || bus.o_data !== pd) begin
                        failures++;
                        $display("FAIL hold: got v=%b %h, required v=1 %h", bus.o_valid, bus.o_data, pd);
                    end
                end
                if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_output: got %h, required no output", bus.o_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.o_data !== e) begin
                            failures++;
                            $display("FAIL data: got %h, required %h", bus.o_data, e);
                        end
                    end
                end
                ps = bus.o_valid && !bus.i_ready;
                pd = bus.o_data;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [DW-1:0] d;
        logic ov, acc;
        rst            = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.i_ready    = 1'b1;
        bus.i_cfg_we   = 1'b0;
        bus.i_cfg_addr = '0;
        bus.i_cfg_a    = '0;
        bus.i_cfg_b    = '0;
`ifdef NFU3_RELU_MODE_EN
        bus.i_relu     = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("reset_o_valid", bus.o_valid, 1'b0);
        check_bit("reset_o_ready", bus.o_ready, 1'b1);
        checks++;
        if (bus.o_data !== '0) begin
            failures++;
            $display("FAIL reset_o_data: got %h, required 0", bus.o_data);
        end
        @(posedge clk);
        #1;

        // Identity table, plus latency of exactly three cycles.
        d = fill2(16'h0C00, 16'h8A00);
        send(d, 1'b1, d, 1'b0, 4'd0, '0, '0);
        idle(ov); check_bit("latency_t1", ov, 1'b0);
        idle(ov); check_bit("latency_t2", ov, 1'b0);
        idle(ov); check_bit("latency_t3", ov, 1'b1);
        drain("identity");

        // Programmed segment 9; segment 11 untouched.
        cfg_write(4'd9, 16'h0200, 16'h0100);
        send(fill2(16'h0600, 16'h0C00), 1'b1, fill2(16'h0400, 16'h0C00), 1'b0, 4'd0, '0, '0);
        drain("segment");

        // Clamp to end segments and saturate.
        cfg_write(4'd15, 16'h7C00, 16'h0000);
        send(fill2(16'h2000, 16'hA000), 1'b1, fill2(16'h7FFF, 16'hA000), 1'b0, 4'd0, '0, '0);
        drain("saturate");

        // Write in the accept cycle is not seen by that vector, only by the next.
        send(fill2(16'h0200, 16'h0200), 1'b1, fill2(16'h0200, 16'h0200), 1'b1, 4'd8, 16'h0000, 16'h0400);
        send(fill2(16'h0200, 16'h0200), 1'b1, fill2(16'h0400, 16'h0400), 1'b0, 4'd0, '0, '0);
        drain("cfg_race");

        // Back-to-back stream with a three-cycle downstream stall.
        ready_mode = 2;
        stream_cyc = 0;
        for (int i = 1; i <= 5; i++) begin
            d = '0;
            for (int k = 1; k < TN; k++) d[k*BW +: BW] = rand_sm(9000);
            d[BW-1:0] = 16'(i * 1024);
            send(d, 1'b0, '0, 1'b0, 4'd0, '0, '0);
        end
        drain("stream");

        // Reset with vectors in flight: nothing emerges, table back to identity.
        send(fill2(16'h0C00, 16'h0600), 1'b0, '0, 1'b0, 4'd0, '0, '0);
        rst = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            idle(ov);
            check_bit($sformatf("flush_t%0d", i), ov, 1'b0);
        end
        d = fill2(16'h0C00, 16'h8A00);
        send(d, 1'b1, d, 1'b0, 4'd0, '0, '0);
        send(fill2(16'h0600, 16'h2000), 1'b1, fill2(16'h0600, 16'h2000), 1'b0, 4'd0, '0, '0);
        drain("post_reset");

        // Random traffic, random backpressure, occasional table writes.
        ready_mode = 1;
        for (int n = 0; n < 400; n++) begin
            logic v, we;
            d = '0;
            for (int k = 0; k < TN; k++) d[k*BW +: BW] = rand_sm(12000);
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 7) == 0);
            cycle(v, d, we, 4'($urandom_range(0, 15)), rand_sm(5000), rand_sm(3000),
                  1'b0, '0, acc, ov);
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
